// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_ctrl_pkg
//  Description : Shared types and default cycle constants for the PLL lock
//                supervisor. Holds the FSM state encoding and the
//                48 MHz default timing values.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_ctrl_pkg;

    // Default timing at a 48 MHz reference clock
    localparam int unsigned c_STABLE_CYCLES  = 4800;    // 100 us of continuous lock
    localparam int unsigned c_GLITCH_CYCLES  = 4;       // extra low cycles tolerated in RUN
    localparam int unsigned c_TIMEOUT_CYCLES = 480000;  // 10 ms without lock
    localparam int unsigned c_PLL_RST_CYCLES = 48;      // PLL reset pulse width
    localparam int          c_CNT_W          = 20;
    localparam int          c_LOSS_W         = 8;

    // Supervisor states; the three spare codes are treated as illegal
    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_PLLRST = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DROP   = 3'd4
    } pll_state_e;

endpackage : pll_ctrl_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchroniser for asynchronous level inputs.
//  Ports       : clk    - destination clock
//                rst_n  - asynchronous active-low reset (flops clear to 0)
//                i_d    - asynchronous input
//                o_q    - synchronised output, two clk edges of latency
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta_q;
    logic [WIDTH-1:0] r_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta_q <= '0;
            r_sync_q <= '0;
        end else begin
            r_meta_q <= i_d;
            r_sync_q <= r_meta_q;
        end
    end

    assign o_q = r_sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_ctrl
//  Description : PLL lock supervisor and reset generator. Synchronises the
//                PLL locked flag, releases the system reset after a period of
//                continuous lock, filters short lock glitches, counts real
//                lock losses and pulses the PLL reset on lock timeout.
//  Ports       : clk         - 48 MHz reference clock
//                resetn      - asynchronous active-low reset
//                locked      - PLL lock flag (asynchronous)
//                clr_status  - synchronous clear of loss_count / timeout_err
//                pll_rst     - active-high reset to the PLL
//                sys_resetn  - active-low reset to downstream logic
//                ready       - high while in RUN or DROP
//                loss_count  - saturating count of declared lock losses
//                timeout_err - sticky lock-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = c_STABLE_CYCLES,
    parameter int unsigned GLITCH_CYCLES  = c_GLITCH_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = c_TIMEOUT_CYCLES,
    parameter int unsigned PLL_RST_CYCLES = c_PLL_RST_CYCLES,
    parameter int          CNT_W          = c_CNT_W,
    parameter int          LOSS_W         = c_LOSS_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              locked,
    input  logic              clr_status,
    output logic              pll_rst,
    output logic              sys_resetn,
    output logic              ready,
    output logic [LOSS_W-1:0] loss_count,
    output logic              timeout_err
);

    // Terminal counts: each state exits on the edge where cnt hits N-1
    localparam logic [CNT_W-1:0]  c_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_GLITCH_LAST  = CNT_W'(GLITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_CNT_INC      = CNT_W'(1);
    localparam logic [LOSS_W-1:0] c_LOSS_INC     = LOSS_W'(1);
    localparam logic [LOSS_W-1:0] c_LOSS_MAX     = {LOSS_W{1'b1}};

    logic              w_locked_s;

    pll_state_e        r_state_q,       w_state_d;
    logic [CNT_W-1:0]  r_cnt_q,         w_cnt_d;
    logic              r_pll_rst_q,     w_pll_rst_d;
    logic              r_sys_resetn_q,  w_sys_resetn_d;
    logic              r_ready_q,       w_ready_d;
    logic [LOSS_W-1:0] r_loss_q,        w_loss_d;
    logic              r_timeout_err_q, w_timeout_err_d;

    logic              w_loss_evt;
    logic              w_timeout_evt;

    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .i_d   (locked),
        .o_q   (w_locked_s)
    );

    // Next-state and counter logic
    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q + c_CNT_INC;
        w_loss_evt    = 1'b0;
        w_timeout_evt = 1'b0;

        case (r_state_q)
            ST_WAIT: begin
                if (w_locked_s) begin
                    w_state_d = ST_STABLE;
                    w_cnt_d   = '0;
                end else if (r_cnt_q == c_TIMEOUT_LAST) begin
                    w_state_d     = ST_PLLRST;
                    w_cnt_d       = '0;
                    w_timeout_evt = 1'b1;
                end
            end
            ST_PLLRST: begin
                // Lock indication is not trusted while the PLL is held in reset
                if (r_cnt_q == c_PLLRST_LAST) begin
                    w_state_d = ST_WAIT;
                    w_cnt_d   = '0;
                end
            end
            ST_STABLE: begin
                if (!w_locked_s) begin
                    w_state_d = ST_WAIT;
                    w_cnt_d   = '0;
                end else if (r_cnt_q == c_STABLE_LAST) begin
                    w_state_d = ST_RUN;
                    w_cnt_d   = '0;
                end
            end
            ST_RUN: begin
                w_cnt_d = '0;
                if (!w_locked_s) begin
                    w_state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (w_locked_s) begin
                    w_state_d = ST_RUN;
                    w_cnt_d   = '0;
                end else if (r_cnt_q == c_GLITCH_LAST) begin
                    w_state_d  = ST_WAIT;
                    w_cnt_d    = '0;
                    w_loss_evt = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_WAIT;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs follow the state being entered
    always_comb begin
        w_pll_rst_d    = (w_state_d == ST_PLLRST);
        w_sys_resetn_d = (w_state_d == ST_RUN) || (w_state_d == ST_DROP);
        w_ready_d      = w_sys_resetn_d;

        // A loss or timeout on the clearing edge still gets recorded
        if (clr_status) begin
            w_loss_d        = w_loss_evt ? c_LOSS_INC : '0;
            w_timeout_err_d = w_timeout_evt;
        end else begin
            w_loss_d        = r_loss_q;
            w_timeout_err_d = r_timeout_err_q | w_timeout_evt;
            if (w_loss_evt && (r_loss_q != c_LOSS_MAX)) begin
                w_loss_d = r_loss_q + c_LOSS_INC;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q       <= ST_WAIT;
            r_cnt_q         <= '0;
            r_pll_rst_q     <= 1'b0;
            r_sys_resetn_q  <= 1'b0;
            r_ready_q       <= 1'b0;
            r_loss_q        <= '0;
            r_timeout_err_q <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_cnt_q         <= w_cnt_d;
            r_pll_rst_q     <= w_pll_rst_d;
            r_sys_resetn_q  <= w_sys_resetn_d;
            r_ready_q       <= w_ready_d;
            r_loss_q        <= w_loss_d;
            r_timeout_err_q <= w_timeout_err_d;
        end
    end

    assign pll_rst     = r_pll_rst_q;
    assign sys_resetn  = r_sys_resetn_q;
    assign ready       = r_ready_q;
    assign loss_count  = r_loss_q;
    assign timeout_err = r_timeout_err_q;

endmodule : pll_lock_ctrl
`default_nettype wire

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
Lock supervisor and reset generator that sits on the consumer side of the board PLL.
- Runs on the stable 48 MHz input clock and synchronises the PLL's asynchronous locked flag.
- Releases the system reset only after lock has been continuous for a set time.
- Filters short lock glitches, counts genuine lock losses, and pulses the PLL reset when lock does not arrive within a timeout.

Parameters:
STABLE_CYCLES, 4800, consecutive synchronised-lock cycles required before release (100 us at 48 MHz)
GLITCH_CYCLES, 4, extra low cycles tolerated in RUN before a loss is declared
TIMEOUT_CYCLES, 480000, cycles in WAIT without lock before a PLL reset pulse (10 ms)
PLL_RST_CYCLES, 48, width of pll_rst pulse in cycles
CNT_W, 20, shared counter width; must hold max(TIMEOUT_CYCLES, STABLE_CYCLES) - 1
LOSS_W, 8, width of loss counter

Ports:
clk  in  1  48 MHz reference clock
resetn  in  1  asynchronous active-low reset
locked  in  1  PLL lock flag, asynchronous to clk
clr_status  in  1  synchronous clear of loss_count and timeout_err
pll_rst  out  1  active-high reset to PLL
sys_resetn  out  1  active-low reset to downstream logic
ready  out  1  high while in RUN or DROP
loss_count  out  LOSS_W  saturating count of declared lock losses
timeout_err  out  1  sticky: at least one lock timeout occurred

Behaviour:
- Reset (async, resetn=0):
  - state=WAIT, cnt=0, sync flops=0.
  - pll_rst=0, sys_resetn=0, ready=0, loss_count=0, timeout_err=0.
  - Takes effect immediately, including mid-RUN.
- locked passes through a 2-FF synchroniser to give locked_s. The FSM sees locked_s; all outputs are registered.
- WAIT: cnt increments each cycle.
  - locked_s=1: go to STABLE, cnt=0.
  - Else if cnt==TIMEOUT_CYCLES-1: go to PLLRST, cnt=0, timeout_err<=1.
- PLLRST: pll_rst=1.
  - When cnt==PLL_RST_CYCLES-1: go to WAIT, cnt=0; pll_rst is 0 from that edge.
  - locked_s is ignored in this state.
- STABLE: cnt increments.
  - locked_s=0: go to WAIT, cnt=0. No loss is counted.
  - Else if cnt==STABLE_CYCLES-1: go to RUN; sys_resetn<=1, ready<=1.
- RUN: locked_s=0 goes to DROP, cnt=0. sys_resetn and ready stay 1.
- DROP: sys_resetn and ready stay 1; cnt increments.
  - locked_s=1: return to RUN.
  - Else if cnt==GLITCH_CYCLES-1: go to WAIT, cnt=0, sys_resetn<=0, ready<=0, loss_count increments (saturating).
  - Net effect: a loss is declared after GLITCH_CYCLES+1 consecutive low locked_s samples.
- Latency:
  - Count edge 1 as the first edge that samples locked=1.
  - sys_resetn rises on edge STABLE_CYCLES+3.
  - A sustained drop deasserts sys_resetn on edge GLITCH_CYCLES+3 after the first low sample.
- clr_status: loss_count<=0 and timeout_err<=0, with two exceptions:
  - A loss declared on the same edge gives loss_count=1.
  - A timeout on the same edge gives timeout_err=1.
- loss_count saturates at 2^LOSS_W-1.
- State encoding: 3 bits. Unreachable codes go to WAIT with outputs deasserted.

Decomposition:
- Package pll_ctrl_pkg: FSM state enum (WAIT, PLLRST, STABLE, RUN, DROP) and the default cycle constants.
- One sub-module, sync2: 2-FF synchroniser with async active-low reset, reused for other CDC inputs.

Test Plan:
All scenarios use STABLE_CYCLES=8, GLITCH_CYCLES=4, TIMEOUT_CYCLES=64, PLL_RST_CYCLES=4, LOSS_W=8.
1. Release resetn, drive locked=1 from edge 1 -> sys_resetn and ready rise on edge 11; pll_rst stays 0; loss_count=0.
2. In RUN, locked low for 4 cycles -> sys_resetn stays 1, loss_count=0. Then low for 5 cycles -> sys_resetn=0 on edge 7 after first low sample, loss_count=1; relocking gives release 11 edges later.
3. locked held 0 -> pll_rst high on edge 64 for exactly 4 cycles, then repeats with period 68; timeout_err=1 after the first pulse.
4. locked high for 5 cycles, then low, during STABLE -> back to WAIT, sys_resetn stays 0, loss_count=0. Next full lock needs a fresh 8-cycle count.
5. Force 256 declared losses -> loss_count=255 (saturated). Then clr_status on the same edge as a loss -> loss_count=1.
6. Assert resetn=0 asynchronously mid-RUN -> sys_resetn, ready, pll_rst and loss_count go 0 without waiting for a clk edge.
